// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select encoding used by the execute stage
// and by anything that drives or checks the ALU.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLT = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7,
      ALU_SRA = 4'd8
   } alu_op_t;

endpackage

// File: rtl/alu32_core.sv
// Purely combinational ALU datapath: shared 33-bit adder/subtractor, logic ops,
// signed compare and barrel shifts, plus the four condition flags.
module alu32_core
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  alu_op_t          op,
   output logic [ALU_W-1:0] y,
   output logic             z,
   output logic             n,
   output logic             c,
   output logic             v
);

   logic             sub;
   logic [ALU_W-1:0] b_eff;
   logic [ALU_W:0]   sum;
   logic [4:0]       shamt;

   // Subtraction reuses the adder as a + ~b + 1, so carry means "no borrow".
   assign sub   = (op == ALU_SUB);
   assign b_eff = sub ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
   assign shamt = b[4:0];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value held over and infer a latch.
      y = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB: begin
            y = sum[ALU_W-1:0];
            c = sum[ALU_W];
            v = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
         end
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         // True signed compare; the sign of a-b is wrong when the subtraction overflows.
         ALU_SLT: y = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL: y = a << shamt;
         ALU_SRL: y = a >> shamt;
         ALU_SRA: y = $signed(a) >>> shamt;
         default: y = '0;
      endcase
   end

   assign z = (y == '0);
   assign n = y[ALU_W-1];

endmodule

// File: rtl/alu32.sv
// Execute-stage ALU: combinational core followed by a single register stage
// for result and flags, giving exactly one cycle of latency.
module alu32
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     op,
   output logic [31:0] y,
   output logic        z,
   output logic        n,
   output logic        c,
   output logic        v
);

   logic [31:0] y_nxt;
   logic        z_nxt;
   logic        n_nxt;
   logic        c_nxt;
   logic        v_nxt;

   alu32_core u_core (
      .a  (a),
      .b  (b),
      .op (op),
      .y  (y_nxt),
      .z  (z_nxt),
      .n  (n_nxt),
      .c  (c_nxt),
      .v  (v_nxt)
   );

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         y <= '0;
         z <= 1'b0;
         n <= 1'b0;
         c <= 1'b0;
         v <= 1'b0;
      end else begin
         y <= y_nxt;
         z <= z_nxt;
         n <= n_nxt;
         c <= c_nxt;
         v <= v_nxt;
      end
   end

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: stimulus pushes expected results, an independent
// monitor pops and compares one cycle after each sampling edge.
module tb_alu32;
   import alu_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] y;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   alu_op_t     op;
   logic [31:0] y;
   logic        z;
   logic        n;
   logic        c;
   logic        v;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   alu32 dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .op  (op),
      .y   (y),
      .z   (z),
      .n   (n),
      .c   (c),
      .v   (v)
   );

   always #5 clk = ~clk;

   // Reference model written from the operation definitions, not the datapath.
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input alu_op_t mop);
      exp_t        e;
      logic [63:0] w;
      longint      sa;
      longint      sb_s;
      longint      s;
      logic [31:0] r;
      sa   = longint'($signed(ma));
      sb_s = longint'($signed(mb));
      e.name = "rand";
      e.c = 1'b0;
      e.v = 1'b0;
      r = '0;
      case (mop)
         ALU_ADD: begin
            w = {32'b0, ma} + {32'b0, mb};
            r = w[31:0];
            e.c = w[32];
            s = sa + sb_s;
            e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         ALU_SUB: begin
            r = ma - mb;
            e.c = (ma >= mb);
            s = sa - sb_s;
            e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         ALU_AND: r = ma & mb;
         ALU_OR:  r = ma | mb;
         ALU_XOR: r = ma ^ mb;
         ALU_SLT: r = (sa < sb_s) ? 32'd1 : 32'd0;
         ALU_SLL: begin
            r = ma;
            for (int i = 0; i < int'(mb[4:0]); i++) r = {r[30:0], 1'b0};
         end
         ALU_SRL: begin
            r = ma;
            for (int i = 0; i < int'(mb[4:0]); i++) r = {1'b0, r[31:1]};
         end
         ALU_SRA: begin
            r = ma;
            for (int i = 0; i < int'(mb[4:0]); i++) r = {r[31], r[31:1]};
         end
         default: r = '0;
      endcase
      e.y = r;
      e.z = (r == 32'd0);
      e.n = r[31];
      return e;
   endfunction

   task automatic drive(input logic r, input logic [31:0] da, input logic [31:0] db,
                        input alu_op_t dop, input exp_t e);
      @(negedge clk);
      rst = r;
      a   = da;
      b   = db;
      op  = dop;
      sb.push_back(e);
   endtask

   task automatic vec(input string nm, input logic r, input logic [31:0] da,
                      input logic [31:0] db, input alu_op_t dop, input logic [31:0] ey,
                      input logic ez, input logic en, input logic ec, input logic ev);
      exp_t e;
      e.name = nm;
      e.y = ey;
      e.z = ez;
      e.n = en;
      e.c = ec;
      e.v = ev;
      drive(r, da, db, dop, e);
   endtask

   // Monitor: outputs change every cycle, so one expected entry per sampled edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({y, z, n, c, v} !== {e.y, e.z, e.n, e.c, e.v}) begin
               bad++;
               $display("FAIL %s: got y=%08h z=%b n=%b c=%b v=%b, want y=%08h z=%b n=%b c=%b v=%b",
                        e.name, y, z, n, c, v, e.y, e.z, e.n, e.c, e.v);
            end
         end
      end
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      alu_op_t     rop;
      int          guard;
      rst = 1'b1;
      a   = 32'd1;
      b   = 32'd1;
      op  = ALU_ADD;

      //   name        rst  a             b             op       y             z  n  c  v
      vec("reset0",    1, 32'd1,        32'd1,        ALU_ADD, 32'h0,        0, 0, 0, 0);
      vec("reset1",    1, 32'd1,        32'd1,        ALU_ADD, 32'h0,        0, 0, 0, 0);
      vec("post_rst",  0, 32'd1,        32'd1,        ALU_ADD, 32'd2,        0, 0, 0, 0);
      vec("add",       0, 32'd10,       32'd20,       ALU_ADD, 32'd30,       0, 0, 0, 0);
      vec("sub",       0, 32'd50,       32'd8,        ALU_SUB, 32'd42,       0, 0, 1, 0);
      vec("sub_neg",   0, 32'd3,        32'd5,        ALU_SUB, 32'hFFFFFFFE, 0, 1, 0, 0);
      vec("sub_eq",    0, 32'd9,        32'd9,        ALU_SUB, 32'h0,        1, 0, 1, 0);
      vec("add_wrap",  0, 32'hFFFFFFFF, 32'd1,        ALU_ADD, 32'h0,        1, 0, 1, 0);
      vec("add_ovf",   0, 32'h7FFFFFFF, 32'd1,        ALU_ADD, 32'h80000000, 0, 1, 0, 1);
      vec("sub_ovf",   0, 32'h80000000, 32'd1,        ALU_SUB, 32'h7FFFFFFF, 0, 0, 1, 1);
      vec("and",       0, 32'h0000F0F0, 32'h00000FF0, ALU_AND, 32'h000000F0, 0, 0, 0, 0);
      vec("or",        0, 32'h0000F0F0, 32'h00000FF0, ALU_OR,  32'h0000FFF0, 0, 0, 0, 0);
      vec("xor",       0, 32'h0000F0F0, 32'h00000FF0, ALU_XOR, 32'h0000FF00, 0, 0, 0, 0);
      vec("slt_t",     0, 32'hFFFFFFFB, 32'd3,        ALU_SLT, 32'd1,        0, 0, 0, 0);
      vec("slt_f",     0, 32'd3,        32'hFFFFFFFB, ALU_SLT, 32'd0,        1, 0, 0, 0);
      vec("slt_ovf",   0, 32'h7FFFFFFF, 32'h80000000, ALU_SLT, 32'd0,        1, 0, 0, 0);
      vec("sll31",     0, 32'd1,        32'd31,       ALU_SLL, 32'h80000000, 0, 1, 0, 0);
      vec("srl4",      0, 32'h80000000, 32'd4,        ALU_SRL, 32'h08000000, 0, 0, 0, 0);
      vec("sra4",      0, 32'h80000000, 32'd4,        ALU_SRA, 32'hF8000000, 0, 1, 0, 0);
      vec("sll_mask",  0, 32'd1,        32'h21,       ALU_SLL, 32'd2,        0, 0, 0, 0);
      vec("illegal",   0, 32'd5,        32'd5,        alu_op_t'(4'd12), 32'h0, 1, 0, 0, 0);
      vec("rst_mid",   1, 32'h7FFFFFFF, 32'd1,        ALU_ADD, 32'h0,        0, 0, 0, 0);
      vec("after_mid", 0, 32'd50,       32'd8,        ALU_SUB, 32'd42,       0, 0, 1, 0);

      for (int i = 0; i < 100; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = alu_op_t'(4'($urandom_range(0, 8)));
         drive(1'b0, ra, rb, rop, model(ra, rb, rop));
      end

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge clk);
         #2;
         guard++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
